instruction_fetch_unit: RTL and testbench

Fetch stage that sits directly downstream of the program counter register. Takes the current PC value, issues a request/ready handshake to instruction memory, captures the returned word into an IF/ID-style holding register, and emits a one-cycle `pc_advance_o` strobe. The next-PC select logic uses that strobe to decide between holding the PC and loading PC+4. The block also handles decode stall, branch/jump flush, misaligned-PC detection and a memory-response timeout.

---
 rtl/mips_fetch_pkg.sv | 8 +
 rtl/instruction_fetch_unit.sv | 88 ++++++++
 tb/tb_instruction_fetch_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared state encoding, fault codes and NOP word for the fetch stage
package mips_fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} fetch_state_t;
  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
  localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC-driven instruction fetch with stall, flush, misalign and timeout handling
module instruction_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int N_BITS = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BITS-1:0] pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [N_BITS-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic [N_BITS-1:0] mem_rdata_i,
  output logic              pc_advance_o,
  output logic [N_BITS-1:0] instr_o,
  output logic [N_BITS-1:0] instr_pc_o,
  output logic              instr_valid_o,
  output logic              fault_o,
  output logic [1:0]        fault_code_o
);
  fetch_state_t state, state_next;
  logic [7:0] cnt, cnt_next;
  logic in_fetch, misaligned, timed_out, accept, waiting, consume;
  // decode the FETCH priority chain and drive the combinational outputs
  always_comb begin
    in_fetch = state == FETCH;
    misaligned = pc_i[1:0] != 2'b00;
    timed_out = cnt == 8'(TIMEOUT_CYCLES);
    accept = in_fetch && !flush_i && !misaligned && !timed_out && mem_ready_i && (!instr_valid_o || !stall_i);
    waiting = in_fetch && !flush_i && !misaligned && !timed_out && !accept;
    mem_req_o = in_fetch && !flush_i && !misaligned;
    mem_addr_o = pc_i;
    pc_advance_o = accept;
    cnt_next = waiting ? (cnt == 8'hff ? cnt : cnt + 8'd1) : 8'd0;
    consume = (in_fetch && (flush_i || (waiting && !stall_i))) || (state == HOLD && (flush_i || !stall_i));
  end
  // next-state selection
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   state_next = flush_i ? FETCH : (misaligned || timed_out) ? FAULT : (accept && stall_i) ? HOLD : FETCH;
      HOLD:    state_next = (flush_i || !stall_i) ? FETCH : HOLD;
      FAULT:   state_next = flush_i ? FETCH : FAULT;
      default: state_next = IDLE;
    endcase
  end
  // state and wait counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 8'd0;
    end else begin
      state <= state_next;
      cnt <= cnt_next;
    end
  end
  // IF/ID holding register: capture on accept, drop when consumed, flushed or faulting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_o <= N_BITS'(NOP);
      instr_pc_o <= '0;
      instr_valid_o <= 1'b0;
    end else if (accept) begin
      instr_o <= mem_rdata_i;
      instr_pc_o <= pc_i;
      instr_valid_o <= 1'b1;
    end else if (consume || state_next == FAULT) begin
      instr_valid_o <= 1'b0;
    end
  end
  // sticky fault flag, cleared only by a flush out of FAULT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_o <= 1'b0;
      fault_code_o <= FAULT_NONE;
    end else if (in_fetch && !flush_i && (misaligned || timed_out)) begin
      fault_o <= 1'b1;
      fault_code_o <= misaligned ? FAULT_MISALIGN : FAULT_TIMEOUT;
    end else if (state == FAULT && flush_i) begin
      fault_o <= 1'b0;
      fault_code_o <= FAULT_NONE;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed table, corner sequences and randomized model check of the fetch unit
module tb_instruction_fetch_unit;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic reset, stall_i, flush_i, mem_ready_i;
  logic [31:0] pc_i, mem_rdata_i;
  logic mem_req_o, pc_advance_o, instr_valid_o, fault_o;
  logic [31:0] mem_addr_o, instr_o, instr_pc_o;
  logic [1:0] fault_code_o;
  int checks = 0;
  int errors = 0;
  instruction_fetch_unit #(.N_BITS(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .pc_i(pc_i), .stall_i(stall_i), .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .pc_advance_o(pc_advance_o), .instr_o(instr_o),
    .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o), .fault_o(fault_o),
    .fault_code_o(fault_code_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pc;
    bit st, fl, rd;
    logic [31:0] dat;
    bit req, adv, val;
    logic [31:0] ins, ipc;
    bit flt;
    logic [1:0] code;
  } vec_t;
  vec_t tbl[22];
  bit m_boot, m_hold, m_fault, m_valid;
  int m_wait;
  logic [31:0] m_instr, m_ipc;
  logic [1:0] m_code;
  function automatic logic [101:0] observed();
    return {mem_req_o, pc_advance_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, fault_o, fault_code_o};
  endfunction
  task automatic chk(input string name, input logic [101:0] act, input logic [101:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (req adv addr valid instr ipc fault code)", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_boot = 1; m_hold = 0; m_fault = 0; m_valid = 0; m_wait = 0;
    m_instr = 0; m_ipc = 0; m_code = 0;
  endtask
  task automatic drive(input logic [31:0] pc, input bit st, input bit fl, input bit rd, input logic [31:0] dat);
    pc_i = pc; stall_i = st; flush_i = fl; mem_ready_i = rd; mem_rdata_i = dat;
  endtask
  task automatic step(input string name, input logic [31:0] pc, input bit st, input bit fl, input bit rd, input logic [31:0] dat);
    bit fetching, bad, take;
    drive(pc, st, fl, rd, dat);
    #1;
    fetching = !m_boot && !m_hold && !m_fault;
    bad = pc[1:0] != 2'b00;
    take = fetching && !fl && !bad && m_wait < TO && rd && (!m_valid || !st);
    chk(name, observed(), {fetching && !fl && !bad, take, pc, m_valid, m_instr, m_ipc, m_fault, m_code});
    if (m_boot) m_boot = 0;
    else if (m_fault) begin
      if (fl) begin m_fault = 0; m_code = 0; end
    end else if (m_hold) begin
      if (fl || !st) begin m_hold = 0; m_valid = 0; end
    end else if (fl) begin
      m_valid = 0; m_wait = 0;
    end else if (bad || m_wait >= TO) begin
      m_fault = 1; m_code = bad ? 2'b01 : 2'b10; m_valid = 0; m_wait = 0;
    end else if (take) begin
      m_instr = dat; m_ipc = pc; m_valid = 1; m_wait = 0; m_hold = st;
    end else begin
      m_wait = m_wait < 255 ? m_wait + 1 : 255;
      if (!st) m_valid = 0;
    end
    @(negedge clk);
  endtask
  task automatic do_reset(input string name);
    reset = 1'b1;
    #1;
    chk(name, {mem_req_o, pc_advance_o, 32'h0, instr_valid_o, instr_o, instr_pc_o, fault_o, fault_code_o}, 102'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{32'h00, 0, 0, 1, 32'h2008_0005, 0, 0, 0, 32'h0, 32'h00, 0, 2'b00};
    tbl[1]  = '{32'h00, 0, 0, 1, 32'h2008_0005, 1, 1, 0, 32'h0, 32'h00, 0, 2'b00};
    tbl[2]  = '{32'h04, 1, 0, 1, 32'h8C09_0010, 1, 0, 1, 32'h2008_0005, 32'h00, 0, 2'b00};
    tbl[3]  = '{32'h04, 0, 0, 1, 32'h8C09_0010, 1, 1, 1, 32'h2008_0005, 32'h00, 0, 2'b00};
    tbl[4]  = '{32'h08, 0, 0, 0, 32'h0, 1, 0, 1, 32'h8C09_0010, 32'h04, 0, 2'b00};
    tbl[5]  = '{32'h08, 1, 0, 1, 32'hAC0A_0020, 1, 1, 0, 32'h8C09_0010, 32'h04, 0, 2'b00};
    tbl[6]  = '{32'h0C, 1, 0, 1, 32'h0, 0, 0, 1, 32'hAC0A_0020, 32'h08, 0, 2'b00};
    tbl[7]  = tbl[6];
    tbl[8]  = tbl[6];
    tbl[9]  = '{32'h0C, 0, 0, 1, 32'h0, 0, 0, 1, 32'hAC0A_0020, 32'h08, 0, 2'b00};
    tbl[10] = '{32'h0C, 0, 0, 1, 32'h012A_4020, 1, 1, 0, 32'hAC0A_0020, 32'h08, 0, 2'b00};
    tbl[11] = '{32'h10, 0, 1, 1, 32'hDEAD_BEEF, 0, 0, 1, 32'h012A_4020, 32'h0C, 0, 2'b00};
    tbl[12] = '{32'h40, 0, 0, 1, 32'h3C01_1000, 1, 1, 0, 32'h012A_4020, 32'h0C, 0, 2'b00};
    tbl[13] = '{32'h06, 0, 0, 1, 32'h0, 0, 0, 1, 32'h3C01_1000, 32'h40, 0, 2'b00};
    tbl[14] = '{32'h06, 0, 0, 0, 32'h0, 0, 0, 0, 32'h3C01_1000, 32'h40, 1, 2'b01};
    tbl[15] = '{32'h80, 0, 1, 0, 32'h0, 0, 0, 0, 32'h3C01_1000, 32'h40, 1, 2'b01};
    tbl[16] = '{32'h80, 0, 0, 0, 32'h0, 1, 0, 0, 32'h3C01_1000, 32'h40, 0, 2'b00};
    tbl[17] = tbl[16];
    tbl[18] = tbl[16];
    tbl[19] = tbl[16];
    tbl[20] = tbl[16];
    tbl[21] = '{32'h80, 0, 0, 0, 32'h0, 0, 0, 0, 32'h3C01_1000, 32'h40, 1, 2'b10};
    drive(32'h0, 0, 0, 1, 32'h2008_0005);
    do_reset("reset_initial");
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].pc, tbl[i].st, tbl[i].fl, tbl[i].rd, tbl[i].dat);
      #1;
      chk($sformatf("table_%0d", i), observed(),
          {tbl[i].req, tbl[i].adv, tbl[i].pc, tbl[i].val, tbl[i].ins, tbl[i].ipc, tbl[i].flt, tbl[i].code});
      @(negedge clk);
    end
    do_reset("reset_after_table");
    step("rst_seq_idle", 32'h100, 0, 0, 1, 32'h1111_2222);
    step("rst_seq_capture", 32'h100, 0, 0, 1, 32'h1111_2222);
    step("rst_seq_wait1", 32'h104, 1, 0, 0, 32'h0);
    step("rst_seq_wait2", 32'h104, 1, 0, 0, 32'h0);
    #3;
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h5555_AAAA;
    do_reset("reset_mid_wait");
    step("post_rst_idle", 32'h104, 0, 0, 1, 32'h5555_AAAA);
    for (int i = 0; i < 6; i++) step($sformatf("post_rst_wait_%0d", i), 32'h104, 0, 0, 0, 32'h0);
    step("post_rst_fault_flush", 32'h200, 0, 1, 0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 15) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      step($sformatf("rand_%0d", i), pc, $urandom_range(0, 9) < 3, $urandom_range(0, 11) == 0,
           $urandom_range(0, 9) < 6, $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
